mux_arbiter: RTL and testbench
==============================

Name: mux_arbiter

Overview:
- Round-robin arbiter that shares one 2:1 word multiplexer between two requesters (A, B).
- Owns the mux select.
- Grants one requester at a time and holds the grant while its request stays high.
- Enforces a bounded hold time so a busy requester cannot starve the other.
- Sits in front of any shared 16-bit datapath resource (bus, ALU input, memory port) fed by two sources.

Parameters:
WIDTH, 16, data word width of each requester input and of out
MAX_HOLD, 4, max consecutive granted cycles while the other side waits; 0 = unlimited (no preemption); legal range 0..255

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
req_a  input  1  requester A wants the resource
req_b  input  1  requester B wants the resource
a  input  WIDTH  requester A data
b  input  WIDTH  requester B data
gnt_a  output  1  A owns the resource (registered)
gnt_b  output  1  B owns the resource (registered)
sel  output  1  mux select: 0 = a, 1 = b (registered)
busy  output  1  some requester holds a grant (= gnt_a | gnt_b)
out  output  WIDTH  sel ? b : a while busy; all-zero when idle (combinational from registered state)

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset state when reset is high at a rising edge:
  - state = IDLE, gnt_a = gnt_b = 0, sel = 0, busy = 0, out = 0.
  - hold counter = 0.
  - last_grant = B, so A wins the first tie.
- Reset overrides everything, including mid-grant; the grant drops on that edge with no completion cycle.
- States:
  - IDLE: no grant.
  - OWN_A: gnt_a = 1, sel = 0.
  - OWN_B: gnt_b = 1, sel = 1.
- Latency: request sampled at edge n; grant visible after edge n, i.e. 1 cycle from req assertion to gnt.
- IDLE transitions:
  - only req_a -> OWN_A.
  - only req_b -> OWN_B.
  - both -> the side not equal to last_grant.
  - none -> stay IDLE.
- OWN_A transitions (OWN_B symmetric):
  - req_a low and req_b high -> OWN_B directly, no idle bubble.
  - req_a low and req_b low -> IDLE.
  - req_a high, req_b high, MAX_HOLD != 0 and hold counter = MAX_HOLD-1 -> preempt to OWN_B.
  - otherwise stay.
- Hold counter, 8 bits:
  - cleared on every state change and while the other side is not requesting.
  - increments each cycle in OWN_x while the other side requests.
  - saturates at 255.
- last_grant updates to the side entered on every entry to OWN_A/OWN_B; unchanged on entry to IDLE.
- gnt_a and gnt_b are never both 1. sel changes only on the edge where the grant changes.
- Preempted requester whose req is still high re-competes: it regains the grant once the other releases, or once the other exhausts MAX_HOLD.
- Requests are level-sensitive. Deasserting req ends the grant on the next edge. A 1-cycle req pulse still yields a 1-cycle grant.
- Data is not registered. out follows a/b combinationally through the selected path.

Test Plan:
- Reset: assert reset 2 cycles with req_a = req_b = 1 -> gnt_a = gnt_b = 0, busy = 0, out = 16'h0000; release reset -> after next edge gnt_a = 1, sel = 0 (A wins first tie).
- Single requester: req_a = 1 only, a = 16'h1234 -> 1 cycle later gnt_a = 1, out = 16'h1234; hold 10 cycles -> grant never drops (no contention); drop req_a -> next edge busy = 0, out = 0.
- Handoff without bubble: OWN_A, req_b = 1, b = 16'hBEEF, then req_a = 0 -> next edge gnt_b = 1, sel = 1, out = 16'hBEEF, with no cycle where busy = 0.
- Preemption (MAX_HOLD = 4): req_a and req_b both held high from idle -> A granted 4 cycles, B 4 cycles, A 4 cycles, repeating; gnt_a/gnt_b never overlap.
- Round-robin tie: A granted then released to IDLE for 1 cycle, then req_a = req_b = 1 same edge -> gnt_b = 1 (last_grant = A).
- Reset mid-grant: OWN_B with counter = 2, pulse reset 1 cycle -> gnt_b = 0 immediately after edge; with both requesting afterwards -> A granted first, counter restarts at 0.

Source files
------------

// File: rtl/mux_arbiter_if.sv
// Bus between two requesters and the arbiter that owns the shared 2:1 word mux.
interface mux_arbiter_if #(
  parameter int unsigned WIDTH = 16
);
  logic             req_a;
  logic             req_b;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             gnt_a;
  logic             gnt_b;
  logic             sel;
  logic             busy;
  logic [WIDTH-1:0] out;

  // Requester side: drives requests and data, observes grants and the muxed word.
  modport master (
    output req_a, req_b, a, b,
    input  gnt_a, gnt_b, sel, busy, out
  );

  // Arbiter side: samples requests and data, drives grants, select and the muxed word.
  modport slave (
    input  req_a, req_b, a, b,
    output gnt_a, gnt_b, sel, busy, out
  );
endinterface

// File: rtl/mux_arbiter.sv
// Round-robin arbiter with bounded hold time that owns a shared 2:1 word mux.
module mux_arbiter #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned MAX_HOLD = 4
) (
  input logic          clk,
  input logic          reset,
  mux_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : (MAX_HOLD - 1));
  localparam bit PREEMPT_EN = (MAX_HOLD != 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  state_t           state;
  logic             gnt_a_q;
  logic             gnt_b_q;
  logic             sel_q;
  logic             last_b;
  logic [CNT_W-1:0] hold_cnt;

  logic             req_a;
  logic             req_b;
  logic [CNT_W-1:0] hold_inc;
  logic             hold_done;

  assign req_a = bus.req_a;
  assign req_b = bus.req_b;

  // Saturating increment and the "owner has used up its turn" flag.
  assign hold_inc  = (hold_cnt == {CNT_W{1'b1}}) ? hold_cnt : hold_cnt + CNT_W'(1);
  assign hold_done = PREEMPT_EN && (hold_cnt == HOLD_LAST);

  // Grant FSM: state, grants, select, tie-break memory and hold counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      gnt_a_q  <= 1'b0;
      gnt_b_q  <= 1'b0;
      sel_q    <= 1'b0;
      last_b   <= 1'b1;
      hold_cnt <= '0;
    end else begin
      // Counter restarts unless the current owner stays while the other side waits.
      hold_cnt <= '0;
      case (state)
        IDLE: begin
          if (req_a && (!req_b || last_b)) begin
            state   <= OWN_A;
            gnt_a_q <= 1'b1;
            gnt_b_q <= 1'b0;
            sel_q   <= 1'b0;
            last_b  <= 1'b0;
          end else if (req_b) begin
            state   <= OWN_B;
            gnt_a_q <= 1'b0;
            gnt_b_q <= 1'b1;
            sel_q   <= 1'b1;
            last_b  <= 1'b1;
          end
        end
        OWN_A: begin
          if (req_b && (!req_a || hold_done)) begin
            state   <= OWN_B;
            gnt_a_q <= 1'b0;
            gnt_b_q <= 1'b1;
            sel_q   <= 1'b1;
            last_b  <= 1'b1;
          end else if (!req_a) begin
            state   <= IDLE;
            gnt_a_q <= 1'b0;
            gnt_b_q <= 1'b0;
            sel_q   <= 1'b0;
          end else if (req_b) begin
            hold_cnt <= hold_inc;
          end
        end
        OWN_B: begin
          if (req_a && (!req_b || hold_done)) begin
            state   <= OWN_A;
            gnt_a_q <= 1'b1;
            gnt_b_q <= 1'b0;
            sel_q   <= 1'b0;
            last_b  <= 1'b0;
          end else if (!req_b) begin
            state   <= IDLE;
            gnt_a_q <= 1'b0;
            gnt_b_q <= 1'b0;
            sel_q   <= 1'b0;
          end else if (req_a) begin
            hold_cnt <= hold_inc;
          end
        end
        default: begin
          state   <= IDLE;
          gnt_a_q <= 1'b0;
          gnt_b_q <= 1'b0;
          sel_q   <= 1'b0;
        end
      endcase
    end
  end

  // Data path is unregistered: the selected word passes straight through while granted.
  assign bus.gnt_a = gnt_a_q;
  assign bus.gnt_b = gnt_b_q;
  assign bus.sel   = sel_q;
  assign bus.busy  = gnt_a_q | gnt_b_q;
  assign bus.out   = !(gnt_a_q | gnt_b_q) ? '0 : (sel_q ? bus.b : bus.a);

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed table-driven bench for mux_arbiter (WIDTH = 16, MAX_HOLD = 4).
module tb_mux_arbiter;

  localparam int unsigned WIDTH = 16;

  typedef struct {
    logic             rst;
    logic             ra;
    logic             rb;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ega;
    logic             egb;
    logic             esel;
    logic             ebusy;
    logic [WIDTH-1:0] eout;
  } vec_t;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;
  vec_t tbl[$];

  localparam logic [WIDTH-1:0] DA = 16'h1234;
  localparam logic [WIDTH-1:0] DB = 16'hBEEF;

  mux_arbiter_if #(.WIDTH(WIDTH)) bif ();

  mux_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t v(logic rst, logic ra, logic rb, logic [WIDTH-1:0] a,
                             logic [WIDTH-1:0] b, logic ga, logic gb);
    vec_t r;
    r.rst   = rst;
    r.ra    = ra;
    r.rb    = rb;
    r.a     = a;
    r.b     = b;
    r.ega   = ga;
    r.egb   = gb;
    r.esel  = gb;
    r.ebusy = ga | gb;
    r.eout  = ga ? a : (gb ? b : '0);
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs away from the active edge, then sample after it.
  task automatic step(logic rst, logic ra, logic rb, logic [WIDTH-1:0] a, logic [WIDTH-1:0] b);
    @(negedge clk);
    reset     = rst;
    bif.req_a = ra;
    bif.req_b = rb;
    bif.a     = a;
    bif.b     = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    reset     = 1'b1;
    bif.req_a = 1'b0;
    bif.req_b = 1'b0;
    bif.a     = '0;
    bif.b     = '0;

    // Reset held two cycles with both requesting, then A wins the first tie.
    tbl.push_back(v(1, 1, 1, DA, DB, 0, 0));
    tbl.push_back(v(1, 1, 1, DA, DB, 0, 0));
    // Preemption: 4 cycles A, 4 cycles B, 4 cycles A, then B again.
    for (int i = 0; i < 4; i++) tbl.push_back(v(0, 1, 1, DA, DB, 1, 0));
    for (int i = 0; i < 4; i++) tbl.push_back(v(0, 1, 1, DA, DB, 0, 1));
    for (int i = 0; i < 4; i++) tbl.push_back(v(0, 1, 1, DA, DB, 1, 0));
    tbl.push_back(v(0, 1, 1, DA, DB, 0, 1));
    // Single requester held 10 cycles, data followed combinationally.
    tbl.push_back(v(1, 0, 0, DA, DB, 0, 0));
    tbl.push_back(v(0, 1, 0, DA, DB, 1, 0));
    for (int i = 0; i < 9; i++) tbl.push_back(v(0, 1, 0, (i >= 4) ? 16'h5678 : DA, DB, 1, 0));
    tbl.push_back(v(0, 0, 0, DA, DB, 0, 0));
    // Handoff A -> B without an idle bubble.
    tbl.push_back(v(0, 1, 0, DA, DB, 1, 0));
    tbl.push_back(v(0, 1, 1, DA, DB, 1, 0));
    tbl.push_back(v(0, 0, 1, DA, DB, 0, 1));
    tbl.push_back(v(0, 0, 0, DA, DB, 0, 0));
    // Round-robin tie after A was last owner -> B.
    tbl.push_back(v(0, 1, 0, DA, DB, 1, 0));
    tbl.push_back(v(0, 0, 0, DA, DB, 0, 0));
    tbl.push_back(v(0, 1, 1, DA, DB, 0, 1));
    tbl.push_back(v(0, 1, 1, DA, DB, 0, 1));
    tbl.push_back(v(0, 1, 1, DA, DB, 0, 1));
    // Reset mid-grant with counter at 2; A first afterwards with a full 4-cycle turn.
    tbl.push_back(v(1, 1, 1, DA, DB, 0, 0));
    for (int i = 0; i < 4; i++) tbl.push_back(v(0, 1, 1, DA, DB, 1, 0));
    tbl.push_back(v(0, 1, 1, DA, DB, 0, 1));
    // One-cycle request pulse yields one-cycle grant.
    tbl.push_back(v(0, 0, 0, DA, DB, 0, 0));
    tbl.push_back(v(0, 0, 1, DA, 16'h0F0F, 0, 1));
    tbl.push_back(v(0, 0, 0, DA, DB, 0, 0));

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].ra, tbl[i].rb, tbl[i].a, tbl[i].b);
      chk($sformatf("v%0d gnt_a", i), 32'(bif.gnt_a), 32'(tbl[i].ega));
      chk($sformatf("v%0d gnt_b", i), 32'(bif.gnt_b), 32'(tbl[i].egb));
      chk($sformatf("v%0d sel", i),   32'(bif.sel),   32'(tbl[i].esel));
      chk($sformatf("v%0d busy", i),  32'(bif.busy),  32'(tbl[i].ebusy));
      chk($sformatf("v%0d out", i),   32'(bif.out),   32'(tbl[i].eout));
    end

    // Sustained contention with changing data: strict 4/4 alternation, never overlapping.
    step(1, 0, 0, '0, '0);
    chk("seq reset busy", 32'(bif.busy), 32'd0);
    for (int i = 0; i < 40; i++) begin
      logic [WIDTH-1:0] ra_d;
      logic [WIDTH-1:0] rb_d;
      logic             exp_a;
      ra_d  = WIDTH'($urandom);
      rb_d  = WIDTH'($urandom);
      exp_a = ((i / 4) % 2) == 0;
      step(0, 1, 1, ra_d, rb_d);
      chk($sformatf("seq%0d gnt_a", i), 32'(bif.gnt_a), 32'(exp_a));
      chk($sformatf("seq%0d overlap", i), 32'(bif.gnt_a & bif.gnt_b), 32'd0);
      chk($sformatf("seq%0d out", i), 32'(bif.out), 32'(exp_a ? ra_d : rb_d));
    end

    // Owner keeps the grant indefinitely once the other side stops asking.
    step(0, 0, 1, DA, DB);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 1, DA, DB);
      chk($sformatf("solo_b%0d gnt_b", i), 32'(bif.gnt_b), 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
